sync_mem_fifo: RTL and testbench
================================

# sync_mem_fifo

Single-clock FIFO controller that drives a synchronous-read dual-port RAM from both ends: it writes an input stream into the RAM and reads it back out in order. It sits between a ready/valid producer and consumer and is the first user of our registered-read memory style. The RAM's registered read data doubles as the FIFO output register, giving first-word-fall-through behaviour.

## Interface
- `WIDTH`, 4, data width in bits.
- `DEPTH`, 16, total capacity in entries; power of two, ≥ 2.
- `AW` (localparam), $clog2(DEPTH), pointer width.
- `clk`  input  1  clock; all state updates on posedge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `in_valid`  input  1  producer has data.
- `in_ready`  output  1  FIFO can accept; `= (count != DEPTH)`.
- `in_data`  input  WIDTH  write data.
- `out_valid`  output  1  `out_data` holds the oldest entry.
- `out_ready`  input  1  consumer takes the entry.
- `out_data`  output  WIDTH  oldest entry; the RAM read register.
- `count`  output  AW+1  entries accepted and not yet popped, 0..DEPTH.

## Operation
- Push when `in_valid && in_ready` at the edge: RAM[wr_ptr] <= in_data; wr_ptr increments mod DEPTH.
- Pop when `out_valid && out_ready` at the edge.
- Read port: read enable and address are combinational from the current state.
  - Read enable is high when the output stage must load: empty-output with stored entries pending, or a pop with another entry behind it.
  - The RAM read register loads RAM[rd_ptr]; rd_ptr increments on each issued read.
  - With read enable low, the read register holds.
- `count`: +1 on push only, −1 on pop only, unchanged on both or neither.
- `out_valid` sets on the edge an issued read completes and clears on a pop with no entry behind it.
- No bypass: a write and a read of the same address never occur in the same cycle, because the read is issued only for an entry already written at an earlier edge.
- Full (`count == DEPTH`): `in_ready` = 0. A simultaneous pop frees a slot for the next cycle, not the current one.
- Empty (`count == 0`): `out_valid` = 0. `out_data` holds its last value and is don't-care.
- Pointers wrap DEPTH−1 → 0 silently. Full and empty are distinguished by `count`, not by pointer compare.
- Reset while busy: all entries are discarded immediately. RAM contents are not cleared and are not observable afterwards.

## Timing
- Reset values: `count` = 0, `in_ready` = 1, `out_valid` = 0, `out_data` = 0, wr_ptr = rd_ptr = 0.
- Latency into an empty FIFO: push at edge N → `out_valid` = 1 after edge N+1, with `out_data` = that word.
- Back-to-back pops: with ≥ 2 entries present, a pop at edge N presents the next word after edge N, so the sustained rate is 1 word/cycle.
- Sustained throughput: 1 push and 1 pop per cycle, count stable.
- `in_ready` depends only on registered `count`, never on `out_ready`. There is no combinational path from any input to `in_ready` or `out_valid`.

## Structure
- Package `sync_mem_fifo_pkg`: default `WIDTH`/`DEPTH` constants and a function for the `count` width.
- Sub-module `sync_dpram`: single-clock RAM of DEPTH×WIDTH.
  - Write port: `we`, `wa`, `wd`.
  - Read port: `re`, `ra`, registered `rd`, resettable to 0.
- Controller, pointers and counter live in `sync_mem_fifo`.
- Formal block under `ifdef FORMAL`:
  - Shadow check on one `const rand` slot.
  - Invariants: `count ≤ DEPTH`; `out_valid == (count != 0)` except in the cycle after the first push into an empty FIFO.

## Test plan
- Reset, then push 0x3 at edge 1, `out_ready` = 0 → `out_valid` = 1 and `out_data` = 0x3 after edge 2; `count` = 1.
- Push 0x0..0xF with no pops → `in_ready` = 0 once `count` = 16. Then drain with `out_ready` = 1 → outputs 0x0..0xF in order, one per cycle, ending with `count` = 0 and `out_valid` = 0.
- Full FIFO, `in_valid` = 1 and `out_ready` = 1 in the same cycle → pop only, `count` = 15. The next cycle accepts the push and `count` returns to 16.
- Steady streaming of an incrementing pattern for 40 cycles with `in_valid` = `out_ready` = 1 → `count` constant, outputs in order, pointers wrap twice with no corruption.
- Random `in_valid`/`out_ready` for 10k cycles against a scoreboard queue → exact ordering, never push when full or pop when empty.
- Assert `rst_n` = 0 mid-stream with `count` = 7 → outputs return immediately to reset values. After release, a push of 0xA emerges first, with no stale data.

Source files
------------

// File: rtl/sync_mem_fifo_pkg.sv
// Shared defaults and sizing helper for the synchronous-RAM FIFO.
package sync_mem_fifo_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_DEPTH = 16;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_dpram.sv
// Single-clock DEPTH x WIDTH RAM: one write port, one registered read port.
// The read register is resettable so the FIFO output has a defined reset value.
module sync_dpram #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             re,
    input  logic [AW-1:0]    ra,
    output logic [WIDTH-1:0] rd
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_q;

    // Storage array write; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wa] <= wd;
        end
    end

    // Registered read; holds its value while re is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (re) begin
            rd_q <= mem_q[ra];
        end
    end

    assign rd = rd_q;

endmodule

// File: rtl/sync_mem_fifo.sv
// Ready/valid FIFO built around sync_dpram. The RAM read register is the
// output register, so the head word is presented first-word-fall-through.
module sync_mem_fifo
    import sync_mem_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;

    logic push, pop, rd_en;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = out_valid_q;
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid_q && out_ready;

    // Entries still in the RAM (not yet in the read register) number
    // count_q - out_valid_q. Load when the output stage is empty and one is
    // pending, or when the head is popped and another entry sits behind it.
    // An entry written at this same edge is never readable yet (no bypass).
    always_comb begin
        rd_en = 1'b0;
        if (!out_valid_q && (count_q != '0)) begin
            rd_en = 1'b1;
        end else if (pop && (count_q > ONE_CNT)) begin
            rd_en = 1'b1;
        end
    end

    // Next-state for pointers, occupancy and the output-valid flag.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase

        if (rd_en) begin
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end

    sync_dpram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push),
        .wa    (wr_ptr_q),
        .wd    (in_data),
        .re    (rd_en),
        .ra    (rd_ptr_q),
        .rd    (out_data)
    );

`ifdef FORMAL
    const rand logic [AW-1:0] f_slot;

    logic [WIDTH-1:0] f_data_q;
    logic             f_live_q;
    logic             f_chk_q;
    logic             f_fresh_q;

    // Shadow one RAM slot: remember what was written, check it on read-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_data_q  <= '0;
            f_live_q  <= 1'b0;
            f_chk_q   <= 1'b0;
            f_fresh_q <= 1'b0;
        end else begin
            f_chk_q <= rd_en && (rd_ptr_q == f_slot);
            if (rd_en && (rd_ptr_q == f_slot)) begin
                f_live_q <= 1'b0;
            end
            if (push && (wr_ptr_q == f_slot)) begin
                f_data_q <= in_data;
                f_live_q <= 1'b1;
            end
            // A push landing while the output stage drains empty leaves one
            // cycle where count is nonzero but nothing is loaded yet.
            f_fresh_q <= push && ((count_q == '0) || (pop && (count_q == ONE_CNT)));
        end
    end

    always_comb begin
        if (rst_n) begin
            assert (count_q <= FULL_CNT);
            if (!f_fresh_q) begin
                assert (out_valid_q == (count_q != '0));
            end
            if (rd_en && (rd_ptr_q == f_slot)) begin
                assert (f_live_q);
                assert (!(push && (wr_ptr_q == f_slot)));
            end
            if (f_chk_q) begin
                assert (out_data == f_data_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_mem_fifo.sv
// Randomised and directed bench for sync_mem_fifo against a queue model.
module tb_sync_mem_fifo;

    localparam int unsigned W = 4;
    localparam int unsigned D = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [4:0]   count;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Model: accepted words with the edge index at which each was pushed.
    // A head word is visible only once at least one edge has passed since
    // its push (the RAM read takes one edge).
    typedef struct {
        logic [W-1:0] data;
        int unsigned  e;
    } ent_t;

    ent_t        q[$];
    int unsigned edge_n = 0;

    sync_mem_fifo #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_valid();
        if (q.size() == 0) return 1'b0;
        return q[0].e < edge_n;
    endfunction

    task automatic compare();
        check_eq("count", 32'(count), 32'(q.size()));
        check_eq("in_ready", 32'(in_ready), 32'(q.size() != D));
        check_eq("out_valid", 32'(out_valid), 32'(m_valid()));
        if (m_valid()) begin
            check_eq("out_data", 32'(out_data), 32'(q[0].data));
        end
    endtask

    // One clock: drive inputs, update the model at the edge, then compare.
    task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ordy);
        bit acc, pp;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        acc = iv && (q.size() < D);
        pp  = ordy && m_valid();
        @(posedge clk);
        edge_n++;
        if (pp) void'(q.pop_front());
        if (acc) q.push_back('{data: d, e: edge_n});
        #1;
        compare();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) begin
            cycle(1'b0, '0, 1'b1);
        end
        check_eq("drained", 32'(count), 32'd0);
    endtask

    initial begin
        logic [W-1:0] k;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;

        // First word latency.
        cycle(1'b1, 4'h3, 1'b0);
        cycle(1'b0, '0, 1'b0);
        check_eq("first_valid", 32'(out_valid), 32'd1);
        check_eq("first_word", 32'(out_data), 32'h3);
        check_eq("first_count", 32'(count), 32'd1);
        drain();

        // Fill to full, reject an extra push, then drain in order.
        for (int i = 0; i < 16; i++) cycle(1'b1, W'(i), 1'b0);
        check_eq("full_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 4'h5, 1'b0);
        check_eq("full_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check_eq("drain_order", 32'(out_data), 32'(i));
            cycle(1'b0, '0, 1'b1);
        end
        check_eq("empty_valid", 32'(out_valid), 32'd0);
        check_eq("empty_count", 32'(count), 32'd0);

        // Push and pop together while full: only the pop happens.
        for (int i = 0; i < 16; i++) cycle(1'b1, W'(15 - i), 1'b0);
        cycle(1'b1, 4'h7, 1'b1);
        check_eq("full_pop_count", 32'(count), 32'd15);
        cycle(1'b1, 4'h7, 1'b0);
        check_eq("full_refill_count", 32'(count), 32'd16);
        drain();

        // Steady streaming with four words resident; pointers wrap twice.
        for (int i = 0; i < 4; i++) cycle(1'b1, W'(i), 1'b0);
        cycle(1'b0, '0, 1'b0);
        k = 4'h4;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, k, 1'b1);
            k = k + 4'h1;
            check_eq("stream_count", 32'(count), 32'd4);
        end
        drain();

        // Random traffic with a bias that changes every 1000 cycles.
        for (int b = 0; b < 10; b++) begin
            int unsigned pin, pout;
            pin  = $urandom_range(1, 3);
            pout = $urandom_range(1, 3);
            for (int i = 0; i < 1000; i++) begin
                cycle(($urandom_range(0, 3) < pin), W'($urandom), ($urandom_range(0, 3) < pout));
            end
        end
        drain();

        // Reset mid-stream with seven entries held.
        for (int i = 0; i < 7; i++) cycle(1'b1, W'(i + 5), 1'b0);
        cycle(1'b0, '0, 1'b0);
        check_eq("pre_rst_count", 32'(count), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_count", 32'(count), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_out_data", 32'(out_data), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 4'hA, 1'b0);
        cycle(1'b0, '0, 1'b0);
        check_eq("post_rst_word", 32'(out_data), 32'hA);
        check_eq("post_rst_count", 32'(count), 32'd1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
